avm_sram_bridge: RTL

AVM_SRAM_BRIDGE -- requirements
Module: avm_sram_bridge

---
 rtl/avm_sram_pkg.sv | 25 ++
 rtl/avm_sram_cmd_fifo.sv | 55 +++++
 rtl/avm_sram_bridge.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/avm_sram_pkg.sv
// Shared widths, timing defaults, command record and FSM states for the Avalon-MM to SRAM bridge.
package avm_sram_pkg;

    localparam int ADDR_W           = 18;
    localparam int DATA_W           = 32;
    localparam int BE_W             = 4;
    localparam int DEF_READ_LATENCY = 3;
    localparam int DEF_ISSUE_GAP    = 3;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP
    } state_t;

endpackage

// File: rtl/avm_sram_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy; the head entry is always visible on rd_data.
module avm_sram_cmd_fifo
    import avm_sram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [CMD_W-1:0] wr_data,
    output logic [CMD_W-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [CMD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);

endmodule

// File: rtl/avm_sram_bridge.sv
// Avalon-MM slave to SRAM controller bridge: queues commands, issues them in order with a fixed gap.
// Define AVM_SRAM_BRIDGE_CMD_FIFO_EN for the FIFO_DEPTH command FIFO; otherwise a single holding register is used.
module avm_sram_bridge
    import avm_sram_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int ISSUE_GAP    = DEF_ISSUE_GAP,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s_address,
    input  logic [BE_W-1:0]   s_byteenable,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [DATA_W-1:0] s_writedata,
    output logic              s_waitrequest,
    output logic [DATA_W-1:0] s_readdata,
    output logic              s_readdatavalid,
    output logic [ADDR_W-1:0] m_address,
    output logic [BE_W-1:0]   m_byteenable,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata
);

    localparam int GAP_LAST  = (ISSUE_GAP > 2) ? ISSUE_GAP - 1 : 1;
    localparam int GAP_CNT_W = $clog2(GAP_LAST + 1);

    state_t                 state;
    state_t                 next_state;
    logic [GAP_CNT_W-1:0]   gap_cnt;
    logic                   gap_done;
    logic                   pending;
    logic                   pop;
    logic                   accept;
    cmd_t                   in_cmd;
    cmd_t                   head_cmd;
    logic [READ_LATENCY:0]  rd_pipe;

    assign accept   = (s_read | s_write) & ~s_waitrequest;
    assign in_cmd   = '{we: s_write, addr: s_address, be: s_byteenable, wdata: s_writedata};
    assign gap_done = (gap_cnt >= GAP_CNT_W'(GAP_LAST));

`ifdef AVM_SRAM_BRIDGE_CMD_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    avm_sram_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (accept),
        .pop    (pop),
        .wr_data(in_cmd),
        .rd_data(head_cmd),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign pending       = ~fifo_empty;
    assign s_waitrequest = reset | (fifo_full & ~pop);
`else
    cmd_t hold_cmd;
    logic hold_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_cmd   <= '0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            hold_cmd   <= in_cmd;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign head_cmd      = hold_cmd;
    assign pending       = hold_valid;
    assign s_waitrequest = reset | hold_valid | (state != ST_IDLE);
`endif

    // The head is popped on the cycle that decides to enter ISSUE, so m_* are registered into that state.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pending) begin
                    next_state = ST_ISSUE;
                    pop        = 1'b1;
                end
            end
            ST_ISSUE: next_state = ST_GAP;
            ST_GAP: begin
                if (gap_done) begin
                    if (pending) begin
                        next_state = ST_ISSUE;
                        pop        = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            gap_cnt      <= '0;
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            m_address    <= '0;
            m_byteenable <= '0;
            m_writedata  <= '0;
        end else begin
            state   <= next_state;
            m_read  <= pop & ~head_cmd.we;
            m_write <= pop & head_cmd.we;
            if (pop) begin
                m_address    <= head_cmd.addr;
                m_byteenable <= head_cmd.be;
                m_writedata  <= head_cmd.wdata;
            end
            if (state == ST_ISSUE) begin
                gap_cnt <= GAP_CNT_W'(1);
            end else if (state == ST_GAP && !gap_done) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    // Bit k marks a read issued k+1 cycles ago; the top bit is the upstream return pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pipe    <= '0;
            s_readdata <= '0;
        end else begin
            rd_pipe <= {rd_pipe[READ_LATENCY-1:0], m_read};
            if (rd_pipe[READ_LATENCY-1]) s_readdata <= m_readdata;
        end
    end

    assign s_readdatavalid = rd_pipe[READ_LATENCY];

endmodule
